// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
//   Datapath constants shared by the register file, the write-register-address
//   mux and the control unit of the multicycle MIPS datapath.
//
//   REG_ZERO      index of the hardwired-zero register ($zero)
//   REG_SP        index of the stack pointer ($sp)
//   REG_RA        index of the return-address register ($ra, jal target)
//   SP_RESET_VAL  value $sp takes on reset
//   DATA_W        datapath word width in bits
//   REG_ADDR_W    register index width (32 architectural registers)
// -----------------------------------------------------------------------------
package register_bank_pkg;

  localparam int REG_ZERO     = 0;
  localparam int REG_SP       = 29;
  localparam int REG_RA       = 31;
  localparam int SP_RESET_VAL = 227;
  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;

  // Convenience types for the default datapath configuration.
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : register_bank_pkg

// File: rtl/register_read_port.sv
// -----------------------------------------------------------------------------
// register_read_port
//   One synchronous read port of the register file. Resolves the value of the
//   addressed register (zero register, write-through bypass, or stored value)
//   and captures it in the output register that serves as the A/B operand latch.
//
//   Ports
//     clk          in   1       rising-edge clock
//     reset        in   1       synchronous active-high reset, clears read_data
//     read_reg     in   ADDR_W  register index to read
//     stored_data  in   DATA_W  current contents of reg[read_reg]
//     write_en     in   1       write port enable (RegWrite)
//     write_reg    in   ADDR_W  write port index
//     write_data   in   DATA_W  write port data
//     read_data    out  DATA_W  registered read result (1-cycle latency)
// -----------------------------------------------------------------------------
module register_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] next_data;

  // Zero check wins over the bypass so a write aimed at $zero never leaks
  // through to a reader of $zero. The bypass is gated by write_en alone, so
  // write_reg/write_data are don't-care while no write is in progress.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves next_data
    // unassigned; otherwise synthesis infers a latch.
    next_data = stored_data;
    if (read_reg == '0) begin
      next_data = '0;
    end else if (write_en && (write_reg == read_reg)) begin
      next_data = write_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      read_data <= next_data;
    end
  end

endmodule : register_read_port

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
//   32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
//   One write port fed by the write-register-address mux, two registered read
//   ports whose outputs act as the A/B operand latches. $zero is hardwired to 0,
//   $sp comes out of reset holding SP_RESET.
//
//   Ports
//     clk        in   1       single clock, rising edge
//     reset      in   1       synchronous active-high reset
//     RegWrite   in   1       write enable
//     WriteReg   in   ADDR_W  destination register index
//     WriteData  in   DATA_W  data to write
//     ReadReg1   in   ADDR_W  read port 1 index (rs)
//     ReadReg2   in   ADDR_W  read port 2 index (rt)
//     ReadData1  out  DATA_W  registered read data, port 1 (A operand)
//     ReadData2  out  DATA_W  registered read data, port 2 (B operand)
// -----------------------------------------------------------------------------
module register_bank
  import register_bank_pkg::*;
#(
  parameter int                DATA_W   = register_bank_pkg::DATA_W,
  parameter int                ADDR_W   = REG_ADDR_W,
  parameter int                SP_IDX   = REG_SP,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:DEPTH-1];
  logic              write_fire;

  // Writes to $zero are discarded at the storage so regs[0] stays 0 forever.
  assign write_fire = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

  // Reset has priority: a write presented in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is a bank of flops, not a RAM macro, so every entry
      // can and must be reset; a memory that maps to RAM would not be.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (write_fire) begin
      regs[WriteReg] <= WriteData;
    end
  end

  register_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .clk         (clk),
    .reset       (reset),
    .read_reg    (ReadReg1),
    .stored_data (regs[ReadReg1]),
    .write_en    (RegWrite),
    .write_reg   (WriteReg),
    .write_data  (WriteData),
    .read_data   (ReadData1)
  );

  register_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .clk         (clk),
    .reset       (reset),
    .read_reg    (ReadReg2),
    .stored_data (regs[ReadReg2]),
    .write_en    (RegWrite),
    .write_reg   (WriteReg),
    .write_data  (WriteData),
    .read_data   (ReadData2)
  );

endmodule : register_bank

// File: tb/tb_register_bank.sv
// -----------------------------------------------------------------------------
// tb_register_bank
//   Self-checking bench for register_bank: a table of directed vectors with
//   hand-derived expectations, a few multi-cycle sequences and a random phase
//   checked against an independent reference model through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_register_bank;
  import register_bank_pkg::*;

  logic     clk;
  logic     reset;
  logic     RegWrite;
  reg_idx_t WriteReg;
  word_t    WriteData;
  reg_idx_t ReadReg1;
  reg_idx_t ReadReg2;
  word_t    ReadData1;
  word_t    ReadData2;

  register_bank dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     rst;
    logic     we;
    reg_idx_t wr;
    word_t    wd;
    reg_idx_t r1;
    reg_idx_t r2;
    word_t    e1;
    word_t    e2;
    string    name;
  } vec_t;

  typedef struct packed {
    word_t e1;
    word_t e2;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb_q[$];
  word_t model_regs [0:31];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic vec_t mk(input logic rst, input logic we, input int wr,
                              input word_t wd, input int r1, input int r2,
                              input word_t e1, input word_t e2, input string name);
    vec_t v;
    v.rst = rst; v.we = we; v.wr = reg_idx_t'(wr); v.wd = wd;
    v.r1 = reg_idx_t'(r1); v.r2 = reg_idx_t'(r2); v.e1 = e1; v.e2 = e2;
    v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input word_t actual, input word_t expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: value(i) resolved from pre-edge state, then the write.
  function automatic word_t model_value(input reg_idx_t idx, input logic we,
                                        input reg_idx_t wr, input word_t wd);
    if (idx == 0) return '0;
    if (we && wr == idx) return wd;
    return model_regs[idx];
  endfunction

  task automatic model_step(input logic rst, input logic we, input reg_idx_t wr,
                            input word_t wd, input reg_idx_t r1, input reg_idx_t r2,
                            output word_t e1, output word_t e2);
    if (rst) begin
      e1 = '0;
      e2 = '0;
      for (int i = 0; i < 32; i++) model_regs[i] = (i == REG_SP) ? word_t'(SP_RESET_VAL) : '0;
    end else begin
      e1 = model_value(r1, we, wr, wd);
      e2 = model_value(r2, we, wr, wd);
      if (we && wr != 0) model_regs[wr] = wd;
    end
  endtask

  // Drive one cycle, push its expectation, then pop and compare after the edge.
  task automatic apply(input logic rst, input logic we, input reg_idx_t wr,
                       input word_t wd, input reg_idx_t r1, input reg_idx_t r2,
                       input word_t e1, input word_t e2, input string name);
    exp_t e;
    @(negedge clk);
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2;
    sb_q.push_back('{e1: e1, e2: e2});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({name, ".rd1"}, ReadData1, e.e1);
      check({name, ".rd2"}, ReadData2, e.e2);
    end
  endtask

  // Model-driven cycle for sequences whose expectations come from the model.
  task automatic model_cycle(input logic rst, input logic we, input reg_idx_t wr,
                             input word_t wd, input reg_idx_t r1, input reg_idx_t r2,
                             input string name);
    word_t e1, e2;
    model_step(rst, we, wr, wd, r1, r2, e1, e2);
    apply(rst, we, wr, wd, r1, r2, e1, e2, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t e1, e2;
    reset = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Directed vectors: expectations derived by hand.
    vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 32'h0,        32'h0,        "reset"));
    vecs.push_back(mk(0, 0,  0, 32'h0,       29,  0, 32'd227,      32'h0,        "sp_reset"));
    vecs.push_back(mk(0, 1,  8, 32'hDEADBEEF, 0,  0, 32'h0,        32'h0,        "wr8"));
    vecs.push_back(mk(0, 0,  0, 32'h0,        8, 29, 32'hDEADBEEF, 32'd227,      "rd8"));
    vecs.push_back(mk(0, 1,  0, 32'hFFFFFFFF, 0,  0, 32'h0,        32'h0,        "wr0_bypass"));
    vecs.push_back(mk(0, 0,  0, 32'h0,        0,  0, 32'h0,        32'h0,        "rd0"));
    vecs.push_back(mk(0, 1,  5, 32'h1234,     5,  5, 32'h1234,     32'h1234,     "bypass5"));
    vecs.push_back(mk(0, 0,  0, 32'h0,        5,  8, 32'h1234,     32'hDEADBEEF, "rd5_8"));
    vecs.push_back(mk(0, 1, 30, 32'hFFFFFFFF,30,  1, 32'hFFFFFFFF, 32'h0,        "bypass30"));
    vecs.push_back(mk(1, 1, 29, 32'h55,      29,  8, 32'h0,        32'h0,        "reset_wr"));
    vecs.push_back(mk(0, 0,  0, 32'h0,       29,  8, 32'd227,      32'h0,        "post_reset"));
    vecs.push_back(mk(0, 0,  0, 32'h0,        5, 30, 32'h0,        32'h0,        "cleared"));
    vecs.push_back(mk(0, 1, REG_RA, 32'h00400010, 0, 0, 32'h0,     32'h0,        "wr31"));
    vecs.push_back(mk(0, 1, 29, 32'h100,     31,  0, 32'h00400010, 32'h0,        "wr29"));
    vecs.push_back(mk(0, 0,  0, 32'h0,       31, 29, 32'h00400010, 32'h100,      "rd31_29"));
    vecs.push_back(mk(0, 0,  7, 32'hAAAAAAAA, 7,  7, 32'h0,        32'h0,        "no_we"));
    vecs.push_back(mk(0, 0,  0, 32'h0,        7, 31, 32'h0,        32'h00400010, "x_safe"));

    for (int i = 0; i < vecs.size(); i++) begin
      model_step(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd,
                 vecs[i].r1, vecs[i].r2, e1, e2);
      apply(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd,
            vecs[i].r1, vecs[i].r2, vecs[i].e1, vecs[i].e2, vecs[i].name);
    end

    // Back-to-back writes to one register with both ports reading it.
    model_cycle(0, 1, 12, 32'h11111111, 12, 12, "b2b_a");
    model_cycle(0, 1, 12, 32'h22222222, 12, 3,  "b2b_b");
    model_cycle(0, 0, 12, 32'h33333333, 12, 12, "b2b_c");

    // Reset held several cycles while writes are presented, then read back.
    model_cycle(0, 1, 20, 32'hCAFEF00D, 20, 0,  "pre_rst");
    model_cycle(1, 1, 20, 32'h0BADBEEF, 20, 29, "rst_hold_a");
    model_cycle(1, 1, 29, 32'h12345678, 20, 29, "rst_hold_b");
    model_cycle(0, 0, 0,  32'h0,        20, 29, "rst_release");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic     rst, we;
      reg_idx_t wr, r1, r2;
      word_t    wd;
      rst = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 1) == 1;
      wr  = reg_idx_t'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = ($urandom_range(0, 3) == 0) ? wr : reg_idx_t'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wr : reg_idx_t'($urandom_range(0, 31));
      model_cycle(rst, we, wr, wd, r1, r2, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_register_bank
